// File: rtl/fg_pkg.sv
// fg_pkg
// Shared definitions for the waveform analyzer: FSM state encoding and the
// default counter / waveform widths used by the analyzer and its counters.
package fg_pkg;

   localparam int FG_COUNTER_BITWIDTH  = 32;
   localparam int FG_WAVEFORM_BITWIDTH = 16;

   typedef enum logic [2:0] {
      ST_ARM  = 3'd0,
      ST_LOW  = 3'd1,
      ST_RISE = 3'd2,
      ST_HIGH = 3'd3,
      ST_FALL = 3'd4
   } fg_state_t;

endpackage

// File: rtl/fg_sat_counter.sv
// fg_sat_counter
// Saturating up-counter with synchronous load. Load has priority over
// increment; the count sticks at all-ones instead of wrapping.
// Ports:
//   i_clk      clock (rising edge)
//   i_rst      synchronous active-high reset, clears the count
//   i_en       increment enable
//   i_load     load i_load_val
//   i_load_val value loaded when i_load=1
//   o_count    current count
module fg_sat_counter
   import fg_pkg::*;
#(
   parameter int WIDTH = FG_COUNTER_BITWIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fg_waveform_analyzer.sv
// fg_waveform_analyzer
// Measures a periodic waveform with a hysteresis FSM (ARM/LOW/RISE/HIGH/FALL).
// A period starts on every LOW->RISE crossing; at each start the counts of
// the previous complete period are published together with its peak sample.
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   clk_en_i              sample strobe, one sample per enabled clock
//   enable_i              measurement enable
//   sample_i              signed sample (WAVEFORM_BITWIDTH+1 bits)
//   thr_low_i/thr_high_i  unsigned hysteresis thresholds
//   timeout_i             maximum period in samples, 0 disables
//   period_o/on_o/rise_o/fall_o  sample counts of the last complete period
//   peak_o                maximum sample of the last complete period
//   valid_o, timeout_o    single-clock pulses
module fg_waveform_analyzer
   import fg_pkg::*;
#(
   parameter int COUNTER_BITWIDTH  = FG_COUNTER_BITWIDTH,
   parameter int WAVEFORM_BITWIDTH = FG_WAVEFORM_BITWIDTH
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clk_en_i,
   input  logic                                enable_i,
   input  logic signed [WAVEFORM_BITWIDTH:0]   sample_i,
   input  logic        [WAVEFORM_BITWIDTH-1:0] thr_low_i,
   input  logic        [WAVEFORM_BITWIDTH-1:0] thr_high_i,
   input  logic        [COUNTER_BITWIDTH-1:0]  timeout_i,
   output logic        [COUNTER_BITWIDTH-1:0]  period_o,
   output logic        [COUNTER_BITWIDTH-1:0]  on_o,
   output logic        [COUNTER_BITWIDTH-1:0]  rise_o,
   output logic        [COUNTER_BITWIDTH-1:0]  fall_o,
   output logic signed [WAVEFORM_BITWIDTH:0]   peak_o,
   output logic                                valid_o,
   output logic                                timeout_o
);

   localparam int CW = COUNTER_BITWIDTH;
   localparam int SW = WAVEFORM_BITWIDTH + 1;

   fg_state_t            r_state;
   fg_state_t            w_next;
   logic                 r_armed;
   logic                 r_valid;
   logic                 r_timeout;
   logic [CW-1:0]        r_period;
   logic [CW-1:0]        r_on;
   logic [CW-1:0]        r_rise;
   logic [CW-1:0]        r_fall;
   logic signed [SW-1:0] r_peak_out;
   logic signed [SW-1:0] r_peak;

   logic w_cfg_ok, w_step, w_le_low, w_ge_high, w_tmo_hit;
   logic w_start, w_runt, w_tmo, w_do_start, w_clear, w_load;
   logic [CW-1:0] w_one;
   logic [CW-1:0] w_period_cnt, w_rise_cnt, w_on_cnt, w_fall_cnt;
   // Low time is counted so the period breakdown is complete, but it has no
   // output port of its own.
   logic [CW-1:0] w_low_cnt_unused;

   // Thresholds are zero-extended so a negative sample is always below them.
   assign w_le_low  = (sample_i <= $signed({1'b0, thr_low_i}));
   assign w_ge_high = (sample_i >= $signed({1'b0, thr_high_i}));
   assign w_cfg_ok  = enable_i && (thr_low_i < thr_high_i);
   assign w_step    = clk_en_i && w_cfg_ok;
   assign w_tmo_hit = (timeout_i != '0) && (w_period_cnt >= timeout_i) &&
                      (r_state != ST_ARM);

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_runt  = 1'b0;
      w_tmo   = 1'b0;
      case (r_state)
         ST_ARM:  if (w_le_low) w_next = ST_LOW;
         ST_LOW:  if (!w_le_low) begin
                     w_next  = ST_RISE;
                     w_start = 1'b1;
                  end
         ST_RISE: if (w_ge_high) w_next = ST_HIGH;
                  else if (w_le_low) begin
                     w_next = ST_LOW;
                     w_runt = 1'b1;
                  end
         ST_HIGH: if (!w_ge_high) w_next = ST_FALL;
         ST_FALL: if (w_le_low) w_next = ST_LOW;
                  else if (w_ge_high) begin
                     w_next = ST_HIGH;
                     w_runt = 1'b1;
                  end
         default: w_next = ST_ARM;
      endcase
      // A period start wins over a coincident timeout.
      if (w_tmo_hit && !w_start) begin
         w_next = ST_ARM;
         w_tmo  = 1'b1;
         w_runt = 1'b0;
      end
   end

   // Counters restart from zero whenever the FSM is (or is being sent) to ARM.
   assign w_do_start = w_step && w_start;
   assign w_clear    = !w_cfg_ok ||
                       (w_step && (w_tmo || (r_state == ST_ARM && w_next == ST_ARM)));
   assign w_load     = w_clear || w_do_start;
   assign w_one      = {{(CW-1){1'b0}}, w_do_start};

   fg_sat_counter #(.WIDTH(CW)) u_period_cnt (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(w_step), .i_load(w_load),
      .i_load_val(w_one), .o_count(w_period_cnt));

   fg_sat_counter #(.WIDTH(CW)) u_low_cnt (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(w_step && (w_next == ST_LOW)), .i_load(w_load),
      .i_load_val('0), .o_count(w_low_cnt_unused));

   fg_sat_counter #(.WIDTH(CW)) u_rise_cnt (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(w_step && (w_next == ST_RISE)), .i_load(w_load),
      .i_load_val(w_one), .o_count(w_rise_cnt));

   fg_sat_counter #(.WIDTH(CW)) u_on_cnt (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(w_step && (w_next == ST_HIGH)), .i_load(w_load),
      .i_load_val('0), .o_count(w_on_cnt));

   fg_sat_counter #(.WIDTH(CW)) u_fall_cnt (
      .i_clk(clk_i), .i_rst(rst_i), .i_en(w_step && (w_next == ST_FALL)), .i_load(w_load),
      .i_load_val('0), .o_count(w_fall_cnt));

   // Running peak of the current period; always reloaded at a start, so it
   // needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_do_start) begin
         r_peak <= sample_i;
      end else if (w_step && (sample_i > r_peak)) begin
         r_peak <= sample_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_ARM;
         r_armed    <= 1'b0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
         r_period   <= '0;
         r_on       <= '0;
         r_rise     <= '0;
         r_fall     <= '0;
         r_peak_out <= '0;
      end else begin
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         if (!w_cfg_ok) begin
            r_state <= ST_ARM;
            r_armed <= 1'b0;
         end else if (clk_en_i) begin
            r_state   <= w_next;
            r_timeout <= w_tmo;
            if (w_start) begin
               r_armed <= 1'b1;
               // Publish only if the period just closed was seen from its start.
               if (r_armed) begin
                  r_valid    <= 1'b1;
                  r_period   <= w_period_cnt;
                  r_on       <= w_on_cnt;
                  r_rise     <= w_rise_cnt;
                  r_fall     <= w_fall_cnt;
                  r_peak_out <= r_peak;
               end
            end else if (w_runt || w_tmo) begin
               r_armed <= 1'b0;
            end
         end
      end
   end

   assign period_o  = r_period;
   assign on_o      = r_on;
   assign rise_o    = r_rise;
   assign fall_o    = r_fall;
   assign peak_o    = r_peak_out;
   assign valid_o   = r_valid;
   assign timeout_o = r_timeout;

endmodule

// File: tb/tb_fg_waveform_analyzer.sv
// Bench for fg_waveform_analyzer: a 32-bit and a 4-bit counter instance
// share the same stimulus and are checked against a sample-list model.
module tb_fg_waveform_analyzer;

   localparam int CW  = 32;
   localparam int CW2 = 4;
   localparam int WW  = 16;
   localparam int SW  = WW + 1;

   localparam int M_ARM  = 0;
   localparam int M_LOW  = 1;
   localparam int M_RISE = 2;
   localparam int M_HIGH = 3;
   localparam int M_FALL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_i    = 1'b1;
   logic                 clk_en   = 1'b1;
   logic                 enable   = 1'b1;
   logic signed [SW-1:0] sample   = '0;
   logic [WW-1:0]        thr_low  = 16'd20;
   logic [WW-1:0]        thr_high = 16'd80;
   logic [CW-1:0]        timeout  = '0;
   logic [CW2-1:0]       timeout2;
   assign timeout2 = timeout[CW2-1:0];

   logic [CW-1:0]        a_period, a_on, a_rise, a_fall;
   logic signed [SW-1:0] a_peak;
   logic                 a_valid, a_tmo;
   logic [CW2-1:0]       b_period, b_on, b_rise, b_fall;
   logic signed [SW-1:0] b_peak;
   logic                 b_valid, b_tmo;

   fg_waveform_analyzer #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW)) dut_a (
      .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en), .enable_i(enable),
      .sample_i(sample), .thr_low_i(thr_low), .thr_high_i(thr_high),
      .timeout_i(timeout), .period_o(a_period), .on_o(a_on), .rise_o(a_rise),
      .fall_o(a_fall), .peak_o(a_peak), .valid_o(a_valid), .timeout_o(a_tmo));

   fg_waveform_analyzer #(.COUNTER_BITWIDTH(CW2), .WAVEFORM_BITWIDTH(WW)) dut_b (
      .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en), .enable_i(enable),
      .sample_i(sample), .thr_low_i(thr_low), .thr_high_i(thr_high),
      .timeout_i(timeout2), .period_o(b_period), .on_o(b_on), .rise_o(b_rise),
      .fall_o(b_fall), .peak_o(b_peak), .valid_o(b_valid), .timeout_o(b_tmo));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input int bits);
      longint m;
      m = (longint'(1) << bits) - 1;
      return (v > m) ? m : v;
   endfunction

   // Model: the labels of every sample since the current period began; at a
   // start the published counts are simply tallies over that list.
   int     m_mode  = M_ARM;
   bit     m_armed = 1'b0;
   int     lab_q[$];
   longint m_peak  = 0;
   longint e_period = 0, e_rise = 0, e_on = 0, e_fall = 0, e_peak = 0;
   int     e_valid = 0, e_tmo = 0;

   function automatic longint tally(input int lab);
      longint c = 0;
      foreach (lab_q[i]) if (lab_q[i] == lab) c++;
      return c;
   endfunction

   task automatic model_step();
      int s;
      int tl;
      int th;
      e_valid = 0;
      e_tmo   = 0;
      if (rst_i) begin
         m_mode = M_ARM; m_armed = 1'b0; lab_q.delete();
         e_period = 0; e_rise = 0; e_on = 0; e_fall = 0; e_peak = 0;
         return;
      end
      if (!enable || (thr_low >= thr_high)) begin
         m_mode = M_ARM; m_armed = 1'b0; lab_q.delete();
         return;
      end
      if (!clk_en) return;
      s  = int'(sample);
      tl = int'(thr_low);
      th = int'(thr_high);
      if (m_mode == M_ARM) begin
         if (s <= tl) begin
            m_mode = M_LOW;
            lab_q.push_back(M_LOW);
         end
         return;
      end
      if (m_mode == M_LOW && s > tl) begin
         if (m_armed) begin
            e_valid  = 1;
            e_period = lab_q.size();
            e_rise   = tally(M_RISE);
            e_on     = tally(M_HIGH);
            e_fall   = tally(M_FALL);
            e_peak   = m_peak;
         end
         m_armed = 1'b1;
         lab_q.delete();
         lab_q.push_back(M_RISE);
         m_peak = s;
         m_mode = M_RISE;
         return;
      end
      if (timeout != 0 && longint'(lab_q.size()) >= longint'(timeout)) begin
         e_tmo = 1; m_mode = M_ARM; m_armed = 1'b0; lab_q.delete();
         return;
      end
      case (m_mode)
         M_RISE: if (s >= th) m_mode = M_HIGH;
                 else if (s <= tl) begin m_mode = M_LOW; m_armed = 1'b0; end
         M_HIGH: if (s < th) m_mode = M_FALL;
         M_FALL: if (s <= tl) m_mode = M_LOW;
                 else if (s >= th) begin m_mode = M_HIGH; m_armed = 1'b0; end
         default: ;
      endcase
      lab_q.push_back(m_mode);
      if (s > m_peak) m_peak = s;
   endtask

   // Captures of published results for the directed literal checks.
   longint rep_q[$];
   longint a_last_rise = 0, a_last_on = 0, a_last_fall = 0, a_last_peak = 0;
   longint b_last_period = 0, b_last_rise = 0, b_last_on = 0, b_last_fall = 0;
   int     n_tmo  = 0;
   int     tmo_at = -1;
   int     seg_idx = 0;

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("a_valid",   a_valid, e_valid);
         chk("a_timeout", a_tmo, e_tmo);
         chk("a_period",  a_period, sat(e_period, CW));
         chk("a_rise",    a_rise, sat(e_rise, CW));
         chk("a_on",      a_on, sat(e_on, CW));
         chk("a_fall",    a_fall, sat(e_fall, CW));
         chk("a_peak",    a_peak, e_peak);
         chk("b_valid",   b_valid, e_valid);
         chk("b_timeout", b_tmo, e_tmo);
         chk("b_period",  b_period, sat(e_period, CW2));
         chk("b_rise",    b_rise, sat(e_rise, CW2));
         chk("b_on",      b_on, sat(e_on, CW2));
         chk("b_fall",    b_fall, sat(e_fall, CW2));
         chk("b_peak",    b_peak, e_peak);
         if (a_valid) begin
            rep_q.push_back(longint'(a_period));
            a_last_rise = a_rise; a_last_on = a_on;
            a_last_fall = a_fall; a_last_peak = a_peak;
         end
         if (b_valid) begin
            b_last_period = b_period; b_last_rise = b_rise;
            b_last_on = b_on; b_last_fall = b_fall;
         end
         if (a_tmo) begin
            n_tmo++;
            tmo_at = seg_idx;
         end
      end
   end

   int gap = 0;

   task automatic drive(input int s);
      @(negedge clk);
      seg_idx++;
      sample = SW'(s);
      clk_en = 1'b1;
      for (int k = 0; k < gap; k++) begin
         @(negedge clk);
         clk_en = 1'b0;
      end
   endtask

   // One 29-sample period: 0..90 up, 100 x5, 90..10 down, 0 x5.
   function automatic int wave_sample(input int i);
      if (i < 10) return 10 * i;
      if (i < 15) return 100;
      if (i < 24) return 10 * (24 - i);
      return 0;
   endfunction

   task automatic wave_part(input int from, input int to);
      for (int i = from; i <= to; i++) drive(wave_sample(i));
   endtask

   task automatic wave();
      wave_part(0, 28);
   endtask

   task automatic tail();
      drive(0); drive(10); drive(20); drive(30); drive(40);
   endtask

   task automatic runt();
      int r[11] = '{0, 10, 20, 30, 40, 50, 40, 30, 20, 10, 0};
      for (int i = 0; i < 11; i++) drive(r[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i  = 1'b1;
      clk_en = 1'b1;
      @(negedge clk);
      rst_i  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      int tbase;
      repeat (3) @(negedge clk);
      chk("reset_period", a_period, 0);
      chk("reset_peak", a_peak, 0);
      chk("reset_valid", a_valid, 0);
      chk("reset_b_period", b_period, 0);
      rst_i = 1'b0;

      // Basic measurement, plus 4-bit saturation on the second instance.
      base = rep_q.size();
      wave(); wave(); wave(); tail();
      chk("basic_nvalid", rep_q.size() - base, 3);
      chk("basic_period", rep_q[$], 29);
      chk("basic_rise", a_last_rise, 5);
      chk("basic_on", a_last_on, 9);
      chk("basic_fall", a_last_fall, 5);
      chk("basic_peak", a_last_peak, 100);
      chk("sat4_period", b_last_period, 15);
      chk("sat4_rise", b_last_rise, 5);
      chk("sat4_on", b_last_on, 9);
      chk("sat4_fall", b_last_fall, 5);

      // Runt pulse discards its period and disarms.
      do_reset();
      base = rep_q.size();
      wave(); wave(); runt(); wave(); wave(); tail();
      chk("runt_nvalid", rep_q.size() - base, 4);
      chk("runt_after_period", rep_q[base + 2], 29);
      chk("runt_last_period", rep_q[base + 3], 29);

      // Sample strobe toggling 1,0,0 gives the same results.
      do_reset();
      gap  = 2;
      base = rep_q.size();
      wave(); wave(); wave(); tail();
      gap  = 0;
      chk("strobe_nvalid", rep_q.size() - base, 3);
      chk("strobe_period", rep_q[$], 29);
      chk("strobe_on", a_last_on, 9);
      chk("strobe_peak", a_last_peak, 100);

      // Timeout: start, then a constant mid-level sample.
      do_reset();
      timeout = 8;
      base    = rep_q.size();
      tbase   = n_tmo;
      seg_idx = -1;
      drive(0); drive(10); drive(20); drive(30);
      repeat (12) drive(50);
      chk("timeout_npulse", n_tmo - tbase, 1);
      chk("timeout_index", tmo_at, 11);
      chk("timeout_nvalid", rep_q.size() - base, 0);
      timeout = 0;

      // Reset mid-HIGH.
      do_reset();
      wave(); wave(); wave_part(0, 11);
      chk("midrst_before", a_period, 29);
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("midrst_period", a_period, 0);
      chk("midrst_on", a_on, 0);
      chk("midrst_peak", a_peak, 0);
      chk("midrst_b_period", b_period, 0);
      base = rep_q.size();
      wave_part(12, 28); wave();
      chk("midrst_one_start", rep_q.size() - base, 0);
      wave(); tail();
      chk("midrst_two_starts", rep_q.size() - base, 2);

      // Disable and inverted thresholds hold outputs and disarm.
      do_reset();
      base = rep_q.size();
      wave(); wave_part(0, 11);
      enable = 1'b0;
      repeat (4) drive(50);
      chk("disable_hold_period", a_period, 29);
      chk("disable_nvalid", rep_q.size() - base, 1);
      enable  = 1'b1;
      thr_low = 16'd90;
      repeat (2) drive(100);
      thr_low = 16'd20;
      wave_part(12, 28); wave(); wave(); tail();
      chk("reenable_nvalid", rep_q.size() - base, 3);
      chk("reenable_period", rep_q[$], 29);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
